// File: rtl/fp_shift_sequencer_if.sv
// Handshake and datapath-control bundle between the FP adder controller and the shift sequencer.
// Master drives requests and mantissa status; slave (the sequencer) drives strobes and results.
interface fp_shift_sequencer_if #(
   parameter int EXP_W   = 8,
   parameter int SHAMT_W = 8
);
   logic               start;
   logic [1:0]         mode;
   logic [SHAMT_W-1:0] shift_amt;
   logic [EXP_W-1:0]   exp_in;
   logic               carry_in;
   logic               mant_msb;
   logic               mant_lsb;
   logic               mant_zero;

   logic               ld_mantice;
   logic               shift_right;
   logic               shift_left;
   logic               serin_from_left;
   logic               busy;
   logic               done;
   logic [EXP_W-1:0]   exp_out;
   logic               exp_flag;
   logic               zero_flag;
   logic               sticky;

   modport master (
      output start, mode, shift_amt, exp_in, carry_in, mant_msb, mant_lsb, mant_zero,
      input  ld_mantice, shift_right, shift_left, serin_from_left, busy, done,
      input  exp_out, exp_flag, zero_flag, sticky
   );

   modport slave (
      input  start, mode, shift_amt, exp_in, carry_in, mant_msb, mant_lsb, mant_zero,
      output ld_mantice, shift_right, shift_left, serin_from_left, busy, done,
      output exp_out, exp_flag, zero_flag, sticky
   );
endinterface

// File: rtl/fp_shift_sequencer.sv
// Control FSM for the FP adder mantissa shift register: align, normalize or carry fix-up.
// Latency: done at 2+min(n,MANT_W) for align; start is ignored (not queued) while busy. STICKY_EN enables sticky tracking.
module fp_shift_sequencer #(
   parameter int MANT_W  = 24,
   parameter int EXP_W   = 8,
   parameter int SHAMT_W = 8
) (
   input logic               clk,
   input logic               rst,
   fp_shift_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(MANT_W + 1);
   localparam int SUM_W = ((EXP_W > SHAMT_W) ? EXP_W : SHAMT_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ALIGN, S_NORM, S_CARRY, S_DONE
   } state_t;

   state_t             state_q;
   logic [1:0]         mode_q;
   logic [SHAMT_W-1:0] amt_q;
   logic [EXP_W-1:0]   exp_in_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [EXP_W-1:0]   exp_q;
   logic               exp_flag_q;
   logic               zero_q;

   logic [SUM_W-1:0]   sum_d;
   logic               ovf_d;
   logic [EXP_W-1:0]   align_exp_d;
   logic [EXP_W-1:0]   exp_inc_d;
   logic [CNT_W-1:0]   cnt_init_d;

   // The align exponent uses the uncapped shift amount; only the shift count is capped.
   always_comb begin
      sum_d       = SUM_W'(exp_in_q) + SUM_W'(amt_q);
      ovf_d       = |sum_d[SUM_W-1:EXP_W];
      align_exp_d = ovf_d ? '1 : sum_d[EXP_W-1:0];
      exp_inc_d   = (&exp_q) ? exp_q : exp_q + EXP_W'(1);
      cnt_init_d  = (32'(amt_q) > 32'(MANT_W)) ? CNT_W'(MANT_W) : CNT_W'(amt_q);
   end

`ifdef STICKY_EN
   logic sticky_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         amt_q      <= '0;
         exp_in_q   <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         exp_q      <= '0;
         exp_flag_q <= 1'b0;
         zero_q     <= 1'b0;
`ifdef STICKY_EN
         sticky_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  mode_q     <= bus.mode;
                  amt_q      <= bus.shift_amt;
                  exp_in_q   <= bus.exp_in;
                  carry_q    <= bus.carry_in;
                  exp_flag_q <= 1'b0;
                  zero_q     <= 1'b0;
`ifdef STICKY_EN
                  sticky_q   <= 1'b0;
`endif
                  state_q    <= S_LOAD;
               end
            end
            S_LOAD: begin
               exp_q <= exp_in_q;
               cnt_q <= cnt_init_d;
               case (mode_q)
                  2'b00:   state_q <= (amt_q == '0) ? S_DONE : S_ALIGN;
                  2'b01:   state_q <= S_NORM;
                  2'b10:   state_q <= carry_q ? S_CARRY : S_DONE;
                  default: state_q <= S_DONE;
               endcase
            end
            S_ALIGN: begin
               cnt_q <= cnt_q - CNT_W'(1);
`ifdef STICKY_EN
               sticky_q <= sticky_q | bus.mant_lsb;
`endif
               if (cnt_q == CNT_W'(1)) begin
                  exp_q      <= align_exp_d;
                  exp_flag_q <= ovf_d;
                  state_q    <= S_DONE;
               end
            end
            S_NORM: begin
               if (bus.mant_zero) begin
                  zero_q  <= 1'b1;
                  exp_q   <= '0;
                  state_q <= S_DONE;
               end else if (bus.mant_msb) begin
                  state_q <= S_DONE;
               end else if (exp_q == '0) begin
                  exp_flag_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  exp_q <= exp_q - EXP_W'(1);
               end
            end
            S_CARRY: begin
               exp_q      <= exp_inc_d;
               exp_flag_q <= &exp_inc_d;
               state_q    <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Strobes depend only on the state register and the live mantissa status.
   assign bus.ld_mantice      = (state_q == S_LOAD);
   assign bus.shift_right     = (state_q == S_ALIGN) || (state_q == S_CARRY);
   assign bus.serin_from_left = (state_q == S_CARRY);
   assign bus.shift_left      = (state_q == S_NORM) && !bus.mant_zero && !bus.mant_msb
                                && (exp_q != '0);
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.done            = (state_q == S_DONE);
   assign bus.exp_out         = exp_q;
   assign bus.exp_flag        = exp_flag_q;
   assign bus.zero_flag       = zero_q;

`ifdef STICKY_EN
   assign bus.sticky = sticky_q;
`else
   logic unused_mant_lsb;
   assign unused_mant_lsb = bus.mant_lsb;
   assign bus.sticky      = 1'b0;
`endif
endmodule

// File: tb/tb_fp_shift_sequencer.sv
// Directed bench for fp_shift_sequencer with a behavioural 24-bit shift register closing the loop.
module tb_fp_shift_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_shift_sequencer_if #(.EXP_W(8), .SHAMT_W(8)) bus ();

   fp_shift_sequencer #(.MANT_W(24), .EXP_W(8), .SHAMT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [23:0] mant_r;
   logic [23:0] mant_val;
   assign bus.mant_msb  = mant_r[23];
   assign bus.mant_lsb  = mant_r[0];
   assign bus.mant_zero = (mant_r == 24'd0);

   always @(posedge clk) begin
      if (bus.ld_mantice)       mant_r <= mant_val;
      else if (bus.shift_right) mant_r <= {bus.serin_from_left, mant_r[23:1]};
      else if (bus.shift_left)  mant_r <= {mant_r[22:0], 1'b0};
   end

   int n_cmp = 0;
   int n_err = 0;

   int r_ld, r_sr, r_sl, r_serin, r_multi, r_done_cyc;
   logic r_busy_done, r_busy_after, r_eflag, r_zflag, r_sticky;
   logic [7:0] r_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge after the done cycle.
   task automatic run_op(input logic [1:0] m, input logic [7:0] amt, input logic [7:0] e,
                         input logic c, input logic [23:0] mv, input int pulse_at);
      int cyc;
      bus.mode      = m;
      bus.shift_amt = amt;
      bus.exp_in    = e;
      bus.carry_in  = c;
      mant_val      = mv;
      bus.start     = 1'b1;
      r_ld = 0; r_sr = 0; r_sl = 0; r_serin = 0; r_multi = 0; r_done_cyc = 0;
      r_busy_done = 1'b0;
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         cyc++;
         if (bus.ld_mantice)      r_ld++;
         if (bus.shift_right)     r_sr++;
         if (bus.shift_left)      r_sl++;
         if (bus.serin_from_left) r_serin++;
         if ((32'(bus.ld_mantice) + 32'(bus.shift_right) + 32'(bus.shift_left)) > 1) r_multi++;
         bus.start = (cyc == pulse_at);
         if (bus.done) begin
            r_done_cyc  = cyc;
            r_busy_done = bus.busy;
            r_exp       = bus.exp_out;
            r_eflag     = bus.exp_flag;
            r_zflag     = bus.zero_flag;
            r_sticky    = bus.sticky;
            break;
         end
      end
      @(negedge clk);
      r_busy_after = bus.busy;
      bus.start    = 1'b0;
   endtask

   logic exp_sticky;

   initial begin
      bus.start = 1'b0; bus.mode = 2'b00; bus.shift_amt = '0; bus.exp_in = '0;
      bus.carry_in = 1'b0; mant_val = '0; mant_r = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_exp",   bus.exp_out, 0);
      chk("rst_eflag", bus.exp_flag, 0);
      chk("rst_zflag", bus.zero_flag, 0);
      chk("rst_stick", bus.sticky, 0);
      chk("rst_strb",  {bus.ld_mantice, bus.shift_right, bus.shift_left, bus.serin_from_left}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Align exp 5 by 3
      run_op(2'b00, 8'd3, 8'd5, 1'b0, 24'h800000, 0);
      chk("a3_ld", r_ld, 1);
      chk("a3_sr", r_sr, 3);
      chk("a3_serin", r_serin, 0);
      chk("a3_done_cyc", r_done_cyc, 5);
      chk("a3_busy_done", r_busy_done, 1);
      chk("a3_exp", r_exp, 8);
      chk("a3_eflag", r_eflag, 0);
      chk("a3_idle", r_busy_after, 0);

      // Align beyond the register width is capped at 24 shifts
      run_op(2'b00, 8'd40, 8'd100, 1'b0, 24'hABCDEF, 0);
      chk("a40_sr", r_sr, 24);
      chk("a40_done_cyc", r_done_cyc, 26);
      chk("a40_exp", r_exp, 140);
      chk("a40_eflag", r_eflag, 0);

      run_op(2'b00, 8'd10, 8'd250, 1'b0, 24'h123456, 0);
      chk("aovf_sr", r_sr, 10);
      chk("aovf_exp", r_exp, 255);
      chk("aovf_eflag", r_eflag, 1);

      run_op(2'b00, 8'd0, 8'd77, 1'b0, 24'h123456, 0);
      chk("a0_done_cyc", r_done_cyc, 2);
      chk("a0_sr", r_sr, 0);
      chk("a0_exp", r_exp, 77);

      // Normalize
      run_op(2'b01, 8'd0, 8'd20, 1'b0, 24'h000F00, 0);
      chk("n_sl", r_sl, 12);
      chk("n_done_cyc", r_done_cyc, 15);
      chk("n_exp", r_exp, 8);
      chk("n_eflag", r_eflag, 0);
      chk("n_zflag", r_zflag, 0);
      chk("n_multi", r_multi, 0);

      run_op(2'b01, 8'd0, 8'd20, 1'b0, 24'h000000, 0);
      chk("nz_sl", r_sl, 0);
      chk("nz_zflag", r_zflag, 1);
      chk("nz_exp", r_exp, 0);
      chk("nz_done_cyc", r_done_cyc, 3);

      run_op(2'b01, 8'd0, 8'd3, 1'b0, 24'h000001, 0);
      chk("nu_sl", r_sl, 3);
      chk("nu_exp", r_exp, 0);
      chk("nu_eflag", r_eflag, 1);
      chk("nu_zflag", r_zflag, 0);

      run_op(2'b01, 8'd0, 8'd7, 1'b0, 24'h800000, 0);
      chk("nn_sl", r_sl, 0);
      chk("nn_exp", r_exp, 7);

      // Carry fix-up
      run_op(2'b10, 8'd0, 8'd254, 1'b1, 24'hFFFFFF, 0);
      chk("c1_sr", r_sr, 1);
      chk("c1_serin", r_serin, 1);
      chk("c1_exp", r_exp, 255);
      chk("c1_eflag", r_eflag, 1);
      chk("c1_done_cyc", r_done_cyc, 3);

      run_op(2'b10, 8'd0, 8'd40, 1'b1, 24'hFFFFFF, 0);
      chk("c2_exp", r_exp, 41);
      chk("c2_eflag", r_eflag, 0);

      run_op(2'b10, 8'd0, 8'd254, 1'b0, 24'hFFFFFF, 0);
      chk("c0_done_cyc", r_done_cyc, 2);
      chk("c0_sr", r_sr, 0);
      chk("c0_exp", r_exp, 254);
      chk("c0_eflag", r_eflag, 0);

      run_op(2'b11, 8'd9, 8'd33, 1'b1, 24'h0F0F0F, 0);
      chk("nop_done_cyc", r_done_cyc, 2);
      chk("nop_sr", r_sr + r_sl, 0);
      chk("nop_exp", r_exp, 33);

      // Sticky collection
`ifdef STICKY_EN
      exp_sticky = 1'b1;
`else
      exp_sticky = 1'b0;
`endif
      run_op(2'b00, 8'd3, 8'd10, 1'b0, 24'h000005, 0);
      chk("st_sticky", r_sticky, 32'(exp_sticky));
      run_op(2'b00, 8'd3, 8'd10, 1'b0, 24'h000F00, 0);
      chk("st_clean", r_sticky, 0);

      // Start while busy, including during the done cycle, is dropped
      run_op(2'b00, 8'd3, 8'd5, 1'b0, 24'h800000, 2);
      chk("pb_done_cyc", r_done_cyc, 5);
      chk("pb_sr", r_sr, 3);
      chk("pb_exp", r_exp, 8);
      run_op(2'b11, 8'd0, 8'd9, 1'b0, 24'h800000, 2);
      chk("pd_noqueue", r_busy_after, 0);
      @(negedge clk);
      chk("pd_idle2", bus.busy, 0);

      // Reset in the second align cycle
      bus.mode = 2'b00; bus.shift_amt = 8'd10; bus.exp_in = 8'd5; mant_val = 24'hFFFFFF;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_sr_pre", bus.shift_right, 1);
      #2 rst = 1'b1;
      #1;
      chk("mr_sr", bus.shift_right, 0);
      chk("mr_busy", bus.busy, 0);
      chk("mr_exp", bus.exp_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mr_idle", bus.busy, 0);

      // Normal operation after the abort
      run_op(2'b00, 8'd2, 8'd1, 1'b0, 24'h800000, 0);
      chk("post_sr", r_sr, 2);
      chk("post_exp", r_exp, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
